// File: rtl/io_fifo_pkg.sv
// io_fifo shared constants and helpers.
// Default geometry and pointer-width function.
package io_fifo_pkg;

  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_DEPTH = 256;

  // Address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_fifo_ram.sv
// io_fifo storage array.
// One synchronous write port, one asynchronous read port, no reset.
module io_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with sticky error flags.
// IO_FIFO_FWFT_EN selects first-word-fall-through read.
module io_fifo
  import io_fifo_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AFULL_THRESH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] rd_data;

  io_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

  // Accept decisions, pointer advance and sticky errors
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    ovf_d = (ovf_q && !clr_err) || (push && !push_ok);
    udf_d = (udf_q && !clr_err) || (pop && !pop_ok);
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef IO_FIFO_FWFT_EN
  assign dout_valid = !empty;
  assign dout       = dout_valid ? rd_data : '0;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;

  // Load the head word on pop; valid pulses one cycle
  always_comb begin
    dout_d = dout_q;
    dv_d   = pop_ok;
    if (pop_ok) dout_d = rd_data;
  end

  // Registered read output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q   <= dv_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
`endif

endmodule

// File: tb/tb_io_fifo.sv
// io_fifo bench: directed steps against a queue scoreboard.
// Follows IO_FIFO_FWFT_EN to pick the read timing it expects.
module tb_io_fifo;

  localparam int W = 9;
  localparam int D = 256;
  localparam int AF = D - 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push;
  logic [W-1:0] din;
  logic         pop;
  logic         clr_err;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic [8:0]   count;
  logic         empty, full, almost_full;
  logic         overflow, underflow;

  io_fifo #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_THRESH (AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .din         (din),
    .pop         (pop),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic [W-1:0] last_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_status();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock of stimulus with full model update and checks
  task automatic op(input logic ps, input logic [W-1:0] d,
                    input logic pp, input logic cl);
    logic         pop_ok, push_ok;
    logic [W-1:0] exp_d;
    pop_ok  = pp && (q.size() > 0);
    push_ok = ps && ((q.size() < D) || pop_ok);
    exp_d   = '0;
    push    = ps;
    din     = d;
    pop     = pp;
    clr_err = cl;
    if (pop_ok) exp_d = q.pop_front();
`ifdef IO_FIFO_FWFT_EN
    #1;
    if (pop_ok) begin
      chk("fwft_valid", 32'(dout_valid), 32'd1);
      chk("fwft_dout", 32'(dout), 32'(exp_d));
    end
`endif
    if (push_ok) q.push_back(d);
    m_ovf = (m_ovf && !cl) || (ps && !push_ok);
    m_udf = (m_udf && !cl) || (pp && !pop_ok);
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
`ifndef IO_FIFO_FWFT_EN
    chk("dout_valid", 32'(dout_valid), 32'(pop_ok));
    if (pop_ok) last_dout = exp_d;
    chk("dout", 32'(dout), 32'(last_dout));
`else
    chk("fwft_valid_idle", 32'(dout_valid), 32'(q.size() > 0));
`endif
    chk_status();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_udf"}, 32'(underflow), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dv"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    din     = '0;
    #3;
    chk_reset_state("rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic ordering
    op(1'b1, 9'h1A5, 1'b0, 1'b0);
    op(1'b1, 9'h003, 1'b0, 1'b0);
    op(1'b1, 9'h0FF, 1'b0, 1'b0);
    chk("basic_count3", 32'(count), 32'd3);
    chk("basic_empty0", 32'(empty), 32'd0);
    repeat (3) op(1'b0, '0, 1'b1, 1'b0);
    op(1'b0, '0, 1'b0, 1'b0);

    // Fill to full, watching almost_full and full per step
    for (int i = 0; i < D; i++)
      op(1'b1, W'(i) ^ 9'h0A5, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd256);
    op(1'b1, 9'h1FF, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    op(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Push with pop while full
    op(1'b1, 9'h055, 1'b1, 1'b0);
    chk("full_pp_count", 32'(count), 32'd256);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    while (q.size() > 0) op(1'b0, '0, 1'b1, 1'b0);
    op(1'b0, '0, 1'b0, 1'b0);

    // Underflow handling
    op(1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow), 32'd1);
    op(1'b0, '0, 1'b0, 1'b1);
    chk("udf_clr", 32'(underflow), 32'd0);
    op(1'b1, 9'h011, 1'b1, 1'b0);
    chk("udf_pp_flag", 32'(underflow), 32'd1);
    chk("udf_pp_count", 32'(count), 32'd1);
    op(1'b0, '0, 1'b1, 1'b1);

    // Clear coinciding with a rejected pop keeps the flag
    op(1'b0, '0, 1'b1, 1'b1);
    chk("udf_clr_race", 32'(underflow), 32'd1);
    op(1'b0, '0, 1'b0, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 200; i++) op(1'b1, W'(i * 7), 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) op(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) op(1'b1, W'(i * 13 + 5), 1'b0, 1'b0);
    chk("wrap_count", 32'(count), 32'd100);
    for (int i = 0; i < 100; i++) op(1'b0, '0, 1'b1, 1'b0);

    // Mid-cycle reset with stored data and a sticky flag
    op(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) op(1'b1, W'(i + 3), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd50);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    last_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b1, 9'h100, 1'b0, 1'b0);
    op(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
